kart_motion_controller: RTL and testbench

Per-frame motion sequencer for the player kart. On each frame-start pulse it applies steering and throttle input, fetches cos/sin for the new heading and the terrain tile under the kart, and advances the kart position in sub-pixel fixed point. Its outputs drive the direction and player position inputs of the racer view renderer. It owns the address side of a dedicated trig ROM and a dedicated track-tile ROM; both are 2-cycle-latency BRAMs.

---
 rtl/kart_pkg.sv | 47 ++++
 rtl/kart_motion_controller_if.sv | 35 +++
 rtl/kart_axis_step.sv | 25 ++
 rtl/kart_motion_controller.sv | 181 ++++++++++++++++++
 tb/tb_kart_motion_controller.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/kart_pkg.sv
// Shared types, widths and tuning constants for the kart motion controller.
package kart_pkg;

    localparam int POS_INT_W  = 11;
    localparam int POS_FRAC_W = 9;
    localparam int POS_W      = POS_INT_W + POS_FRAC_W;
    localparam int DIR_W      = 9;
    localparam int SPEED_W    = 5;
    localparam int TRIG_W     = 11;
    localparam int TERRAIN_W  = 4;
    localparam int DELTA_W    = 17;

    localparam logic [DIR_W-1:0]     DIR_FULL     = 9'd360;
    localparam logic [DIR_W-1:0]     TURN_STEP    = 9'd3;
    localparam logic [TERRAIN_W-1:0] TERRAIN_ROAD = 4'd0;

    localparam logic [SPEED_W-1:0] MAX_SPEED   = 5'd16;
    localparam logic [SPEED_W-1:0] OFFROAD_MAX = 5'd6;
    localparam logic [SPEED_W-1:0] ACCEL       = 5'd1;
    localparam logic [SPEED_W-1:0] BRAKE       = 5'd2;
    localparam logic [SPEED_W-1:0] COAST       = 5'd1;

    localparam logic [POS_INT_W-1:0] START_X = 11'd1024;
    localparam logic [POS_INT_W-1:0] START_Y = 11'd1536;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STEER = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LATCH = 3'd4,
        ST_MOVE  = 3'd5
    } kart_state_t;

    // speed * trig in 1/512-pixel units; |result| <= 31*1024 fits 17 bits signed.
    function automatic logic signed [DELTA_W-1:0] scaled_delta(
        input logic        [SPEED_W-1:0] speed,
        input logic signed [TRIG_W-1:0]  trig
    );
        logic signed [DELTA_W-1:0] s_ext;
        logic signed [DELTA_W-1:0] t_ext;
        s_ext = signed'({12'd0, speed});
        t_ext = signed'({{(DELTA_W-TRIG_W){trig[TRIG_W-1]}}, trig});
        return s_ext * t_ext;
    endfunction

endpackage

// File: rtl/kart_motion_controller_if.sv
// Frame control, ROM address/data and renderer-facing signals of the kart controller.
interface kart_motion_controller_if;
    logic               new_frame_in;
    logic               btn_left_in;
    logic               btn_right_in;
    logic               btn_accel_in;
    logic               btn_brake_in;
    logic signed [10:0] cos_in;
    logic signed [10:0] sin_in;
    logic [3:0]         terrain_in;
    logic [8:0]         trig_addr_out;
    logic [7:0]         tile_addr_out;
    logic [8:0]         direction_out;
    logic [10:0]        player_x_out;
    logic [10:0]        player_y_out;
    logic [4:0]         speed_out;
    logic               busy_out;
    logic               done_out;

    // Controller side: owns the ROM addresses and the kart state outputs.
    modport master (
        input  new_frame_in, btn_left_in, btn_right_in, btn_accel_in, btn_brake_in,
        input  cos_in, sin_in, terrain_in,
        output trig_addr_out, tile_addr_out, direction_out,
        output player_x_out, player_y_out, speed_out, busy_out, done_out
    );

    // Environment side: buttons, frame timing, ROM data and the renderer.
    modport slave (
        output new_frame_in, btn_left_in, btn_right_in, btn_accel_in, btn_brake_in,
        output cos_in, sin_in, terrain_in,
        input  trig_addr_out, tile_addr_out, direction_out,
        input  player_x_out, player_y_out, speed_out, busy_out, done_out
    );
endinterface

// File: rtl/kart_axis_step.sv
// One axis of the position update: 11.9 fixed point plus signed delta, saturated to [0, 2047.511].
module kart_axis_step
    import kart_pkg::*;
(
    input  logic        [POS_W-1:0]   pos,
    input  logic signed [DELTA_W-1:0] delta,
    output logic        [POS_W-1:0]   result
);

    logic signed [POS_W+1:0] sum_s;

    // Widen both operands, add, then clamp underflow to 0.0 and overflow to all-ones.
    always_comb begin
        sum_s  = signed'({2'b00, pos}) + signed'({{(POS_W+2-DELTA_W){delta[DELTA_W-1]}}, delta});
        result = sum_s[POS_W-1:0];
        if (sum_s[POS_W+1]) begin
            result = {POS_W{1'b0}};
        end else if (sum_s[POS_W]) begin
            result = {POS_W{1'b1}};
        end else begin
            result = sum_s[POS_W-1:0];
        end
    end

endmodule

// File: rtl/kart_motion_controller.sv
// Per-frame kart sequencer: steer/throttle, fetch trig and tile data, advance position.
module kart_motion_controller
    import kart_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    kart_motion_controller_if.master bus
);

    kart_state_t state_r;
    kart_state_t state_next_s;

    logic        [DIR_W-1:0]     dir_r;
    logic        [SPEED_W-1:0]   speed_r;
    logic        [POS_W-1:0]     pos_x_r;
    logic        [POS_W-1:0]     pos_y_r;
    logic signed [TRIG_W-1:0]    cos_r;
    logic signed [TRIG_W-1:0]    sin_r;
    logic        [TERRAIN_W-1:0] terrain_r;
    logic                        busy_r;
    logic                        done_r;

    logic        [DIR_W-1:0]   dir_steer_s;
    logic        [SPEED_W-1:0] speed_steer_s;
    logic        [SPEED_W-1:0] speed_move_s;
    logic signed [DELTA_W-1:0] delta_x_s;
    logic signed [DELTA_W-1:0] delta_y_s;
    logic        [POS_W-1:0]   pos_x_next_s;
    logic        [POS_W-1:0]   pos_y_next_s;

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: fixed walk through the ROM latency; frame pulses are only seen in IDLE.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (bus.new_frame_in) begin
                    state_next_s = ST_STEER;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STEER: state_next_s = ST_ISSUE;
            ST_ISSUE: state_next_s = ST_WAIT;
            ST_WAIT:  state_next_s = ST_LATCH;
            ST_LATCH: state_next_s = ST_MOVE;
            ST_MOVE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Heading update with wrap into 0..359; opposing buttons cancel.
    always_comb begin
        dir_steer_s = dir_r;
        if (bus.btn_left_in && !bus.btn_right_in) begin
            if (dir_r < TURN_STEP) begin
                dir_steer_s = dir_r + DIR_FULL - TURN_STEP;
            end else begin
                dir_steer_s = dir_r - TURN_STEP;
            end
        end else if (bus.btn_right_in && !bus.btn_left_in) begin
            if ((dir_r + TURN_STEP) >= DIR_FULL) begin
                dir_steer_s = dir_r + TURN_STEP - DIR_FULL;
            end else begin
                dir_steer_s = dir_r + TURN_STEP;
            end
        end else begin
            dir_steer_s = dir_r;
        end
    end

    // Throttle update: brake beats accel, no button means coast.
    always_comb begin
        speed_steer_s = speed_r;
        if (bus.btn_brake_in) begin
            if (speed_r < BRAKE) begin
                speed_steer_s = 5'd0;
            end else begin
                speed_steer_s = speed_r - BRAKE;
            end
        end else if (bus.btn_accel_in) begin
            if (speed_r >= MAX_SPEED) begin
                speed_steer_s = MAX_SPEED;
            end else begin
                speed_steer_s = speed_r + ACCEL;
            end
        end else begin
            if (speed_r < COAST) begin
                speed_steer_s = 5'd0;
            end else begin
                speed_steer_s = speed_r - COAST;
            end
        end
    end

    // Off-road cap applies before the move so the step itself uses the capped speed.
    always_comb begin
        speed_move_s = speed_r;
        if ((terrain_r != TERRAIN_ROAD) && (speed_r > OFFROAD_MAX)) begin
            speed_move_s = OFFROAD_MAX;
        end else begin
            speed_move_s = speed_r;
        end
        delta_x_s = scaled_delta(speed_move_s, sin_r);
        delta_y_s = -scaled_delta(speed_move_s, cos_r);
    end

    kart_axis_step u_step_x (
        .pos    (pos_x_r),
        .delta  (delta_x_s),
        .result (pos_x_next_s)
    );

    kart_axis_step u_step_y (
        .pos    (pos_y_r),
        .delta  (delta_y_s),
        .result (pos_y_next_s)
    );

    // Kart state registers, each written only in its own phase of the frame.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dir_r     <= 9'd0;
            speed_r   <= 5'd0;
            pos_x_r   <= {START_X, 9'd0};
            pos_y_r   <= {START_Y, 9'd0};
            cos_r     <= 11'sd0;
            sin_r     <= 11'sd0;
            terrain_r <= 4'd0;
        end else begin
            case (state_r)
                ST_STEER: begin
                    dir_r   <= dir_steer_s;
                    speed_r <= speed_steer_s;
                end
                ST_LATCH: begin
                    cos_r     <= bus.cos_in;
                    sin_r     <= bus.sin_in;
                    terrain_r <= bus.terrain_in;
                end
                ST_MOVE: begin
                    speed_r <= speed_move_s;
                    pos_x_r <= pos_x_next_s;
                    pos_y_r <= pos_y_next_s;
                end
                default: begin
                    dir_r <= dir_r;
                end
            endcase
        end
    end

    // Registered status: busy spans STEER..MOVE, done pulses for the cycle after MOVE.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_r == ST_MOVE);
        end
    end

    assign bus.direction_out = dir_r;
    assign bus.trig_addr_out = dir_r;
    assign bus.speed_out     = speed_r;
    assign bus.player_x_out  = pos_x_r[POS_W-1:POS_FRAC_W];
    assign bus.player_y_out  = pos_y_r[POS_W-1:POS_FRAC_W];
    assign bus.tile_addr_out = {pos_y_r[POS_W-1:POS_W-4], pos_x_r[POS_W-1:POS_W-4]};
    assign bus.busy_out      = busy_r;
    assign bus.done_out      = done_r;

endmodule

// File: tb/tb_kart_motion_controller.sv
// Directed bench for kart_motion_controller with a small fixed-point reference model.
module tb_kart_motion_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    kart_motion_controller_if bus ();

    kart_motion_controller dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: position in 1/512 pixel units.
    int m_dir, m_speed, m_px, m_py;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_dir   = 0;
        m_speed = 0;
        m_px    = 1024 * 512;
        m_py    = 1536 * 512;
    endtask

    task automatic model_frame(input logic l, input logic r, input logic a, input logic b,
                               input int terr, input int cosv, input int sinv);
        if (l && !r) begin
            m_dir = m_dir - 3;
            if (m_dir < 0) m_dir = m_dir + 360;
        end else if (r && !l) begin
            m_dir = m_dir + 3;
            if (m_dir >= 360) m_dir = m_dir - 360;
        end
        if (b)      m_speed = (m_speed < 2) ? 0 : m_speed - 2;
        else if (a) m_speed = (m_speed >= 16) ? 16 : m_speed + 1;
        else        m_speed = (m_speed < 1) ? 0 : m_speed - 1;
        if (terr != 0 && m_speed > 6) m_speed = 6;
        m_px = m_px + m_speed * sinv;
        m_py = m_py - m_speed * cosv;
        if (m_px < 0) m_px = 0;
        if (m_px > 1048575) m_px = 1048575;
        if (m_py < 0) m_py = 0;
        if (m_py > 1048575) m_py = 1048575;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_dir"},   bus.direction_out, 0);
        check_val({tag, "_x"},     bus.player_x_out, 1024);
        check_val({tag, "_y"},     bus.player_y_out, 1536);
        check_val({tag, "_speed"}, bus.speed_out, 0);
        check_val({tag, "_busy"},  bus.busy_out, 0);
        check_val({tag, "_done"},  bus.done_out, 0);
        check_val({tag, "_tile"},  bus.tile_addr_out, 200);
    endtask

    task automatic set_inputs(input logic l, input logic r, input logic a, input logic b,
                              input int terr, input int cosv, input int sinv);
        bus.btn_left_in  = l;
        bus.btn_right_in = r;
        bus.btn_accel_in = a;
        bus.btn_brake_in = b;
        bus.terrain_in   = 4'(terr);
        bus.cos_in       = 11'(cosv);
        bus.sin_in       = 11'(sinv);
    endtask

    // One complete frame: pulse, wait for done (bounded), compare against the model.
    task automatic run_frame(input logic l, input logic r, input logic a, input logic b,
                             input int terr, input int cosv, input int sinv);
        int cyc;
        set_inputs(l, r, a, b, terr, cosv, sinv);
        model_frame(l, r, a, b, terr, cosv, sinv);
        @(negedge clk);
        bus.new_frame_in = 1'b1;
        @(posedge clk);
        #1;
        bus.new_frame_in = 1'b0;
        cyc = 1;
        check_val("busy_after_e1", bus.busy_out, 1);
        while (bus.done_out !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val("done_latency", cyc, 6);
        check_val("busy_at_done", bus.busy_out, 0);
        check_val("dir",   bus.direction_out, m_dir);
        check_val("trig_addr", bus.trig_addr_out, m_dir);
        check_val("speed", bus.speed_out, m_speed);
        check_val("x",     bus.player_x_out, m_px >>> 9);
        check_val("y",     bus.player_y_out, m_py >>> 9);
        check_val("tile_addr", bus.tile_addr_out, ((m_py >>> 16) * 16) + (m_px >>> 16));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int y_before;
        int dones;
        bus.new_frame_in = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 0, 512, 0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals("reset");

        // Idle frame from reset: nothing moves.
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0, 512, 0);
        check_val("idle_y", bus.player_y_out, 1536);

        // 20 frames of accel heading up: speeds 1..16 then 16 x4, total 200 pixels.
        for (int i = 0; i < 20; i++) run_frame(1'b0, 1'b0, 1'b1, 1'b0, 0, 512, 0);
        check_val("accel_speed_cap", bus.speed_out, 16);
        check_val("accel_y_final", bus.player_y_out, 1336);

        // Steering wrap both ways, and cancelling buttons.
        run_frame(1'b1, 1'b0, 1'b1, 1'b0, 0, 512, 0);
        check_val("left_wrap", bus.direction_out, 357);
        run_frame(1'b0, 1'b1, 1'b1, 1'b0, 0, 512, 0);
        check_val("right_wrap", bus.direction_out, 0);
        run_frame(1'b0, 1'b1, 1'b1, 1'b0, 0, 512, 0);
        check_val("right_step", bus.direction_out, 3);
        run_frame(1'b1, 1'b1, 1'b1, 1'b0, 0, 512, 0);
        check_val("both_hold", bus.direction_out, 3);

        // Off-road clamp takes effect in the same move.
        y_before = int'(bus.player_y_out);
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 2, 512, 0);
        check_val("offroad_speed", bus.speed_out, 6);
        check_val("offroad_dy", y_before - int'(bus.player_y_out), 6);

        // Brake beats accel, floors at 0.
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 0, 512, 0);
        check_val("brake_1", bus.speed_out, 4);
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 0, 512, 0);
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 0, 512, 0);
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 0, 512, 0);
        check_val("brake_floor", bus.speed_out, 0);

        // Drive up until y underflows to 0.
        for (int i = 0; i < 300 && m_py > 0; i++) run_frame(1'b0, 1'b0, 1'b1, 1'b0, 0, 512, 0);
        check_val("y_sat_zero", bus.player_y_out, 0);

        // Drive right with a fractional sine until x saturates.
        for (int i = 0; i < 300 && m_px < 1048575; i++) run_frame(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 300);
        check_val("x_sat_max", bus.player_x_out, 2047);
        check_val("sat_tile", bus.tile_addr_out, 15);
        // 2047+511/512 minus 16/512 stays in pixel 2047; a 2047.0 saturation would drop to 2046.
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, -1);
        check_val("x_sat_frac", bus.player_x_out, 2047);

        // Second frame pulse arriving mid-sequence is dropped.
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        model_frame(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        @(negedge clk);
        bus.new_frame_in = 1'b1;
        @(posedge clk);
        #1;
        bus.new_frame_in = 1'b0;
        @(posedge clk);
        #1;
        bus.new_frame_in = 1'b1;
        @(posedge clk);
        #1;
        bus.new_frame_in = 1'b0;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_out === 1'b1) dones++;
        end
        check_val("midseq_done_count", dones, 1);
        check_val("midseq_speed", bus.speed_out, m_speed);
        check_val("midseq_busy", bus.busy_out, 0);

        // Async reset during the ROM wait aborts the frame without a done pulse.
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 0, 512, 0);
        @(negedge clk);
        bus.new_frame_in = 1'b1;
        @(posedge clk);
        #1;
        bus.new_frame_in = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_out === 1'b1) dones++;
        end
        check_val("abort_no_done", dones, 0);
        check_reset_vals("after_abort");

        // Recovery frame after the abort.
        run_frame(1'b0, 1'b1, 1'b1, 1'b0, 0, 512, 0);
        check_val("recover_dir", bus.direction_out, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
